vp_validator: RTL and testbench

//  Pipeline-side partner of the value-predictor wrapper. It consumes the 2-wide prediction outputs:
//  pc/conf/valid at D, the predicted value at E1. Each valid prediction is held in an in-order

---
 rtl/vp_pkg.sv | 12 +
 rtl/vp_validator_fifo.sv | 59 +++++
 rtl/vp_validator.sv | 131 +++++++++++++
 tb/tb_vp_validator.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared types for the value-predictor validator.
// Entry layout of one tracked prediction and the lane count.
package vp_pkg;
  localparam int VP_NUM_LANES  = 2;
  localparam int VP_CONF_WIDTH = 8;

  typedef struct packed {
    logic [31:1]            pc;
    logic [31:0]            pred;
    logic [VP_CONF_WIDTH:0] conf;
  } vp_entry_t;
endpackage

// File: rtl/vp_validator_fifo.sv
// 2-push / 2-pop circular buffer of tracked predictions.
// Pointers carry one extra wrap bit; count is their difference.
module vp_validator_fifo
  import vp_pkg::*;
#(
  parameter type T        = vp_entry_t,
  parameter int  P_DEPTH  = 16,
  localparam int CNT_W    = $clog2(P_DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic [1:0]              push_n_i,
  input  T [VP_NUM_LANES-1:0]     push_data_i,
  input  logic [1:0]              pop_n_i,
  output T [VP_NUM_LANES-1:0]     head_o,
  output logic [CNT_W-1:0]        count_o
);
  localparam int PW = $clog2(P_DEPTH);
  localparam int AW = PW + 1;

  T              mem_q [P_DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [PW-1:0] wa0, wa1, ra0, ra1;

  assign wa0 = wr_q[PW-1:0];
  assign wa1 = wa0 + 1'b1;
  assign ra0 = rd_q[PW-1:0];
  assign ra1 = ra0 + 1'b1;

  assign head_o[0] = mem_q[ra0];
  assign head_o[1] = mem_q[ra1];
  assign count_o   = CNT_W'(wr_q - rd_q);

  always_comb begin
    rd_d = rd_q + AW'(pop_n_i);
    wr_d = wr_q + AW'(push_n_i);
    if (clr_i) begin
      rd_d = '0;
      wr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_n_i != 2'd0) mem_q[wa0] <= push_data_i[0];
    if (push_n_i == 2'd2) mem_q[wa1] <= push_data_i[1];
  end
endmodule

// File: rtl/vp_validator.sv
// Tracks value predictions in order and compares them with executed
// results, driving mispredict feedback back into the predictor.
module vp_validator
  import vp_pkg::*;
#(
  parameter int  P_CONF_WIDTH = VP_CONF_WIDTH,
  parameter int  P_DEPTH      = 16,
  parameter int  P_DROP_W     = 16,
  localparam int CW           = P_CONF_WIDTH,
  localparam int CNT_W        = $clog2(P_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0][31:1]      pred_pc_d_i,
  input  logic [1:0][CW:0]      pred_conf_d_i,
  input  logic [1:0]            pred_valid_d_i,
  input  logic [1:0][31:0]      pred_result_e1_i,
  input  logic [1:0][31:1]      ex_pc_i,
  input  logic [1:0][31:0]      ex_result_i,
  input  logic [1:0]            ex_valid_i,
  input  logic                  flush_i,
  output logic [1:0][31:1]      fb_pc_o,
  output logic [1:0][31:0]      fb_actual_o,
  output logic [1:0]            fb_mispredict_o,
  output logic [1:0][CW:0]      fb_conf_o,
  output logic [1:0]            fb_valid_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [P_DROP_W-1:0]   drop_cnt_o,
  output logic                  resync_o
);
  typedef struct packed {
    logic [31:1] pc;
    logic [31:0] pred;
    logic [CW:0] conf;
  } entry_t;

  localparam logic [P_DROP_W-1:0] DROP_MAX = '1;

  logic [1:0][31:1]    d_pc_q;
  logic [1:0][CW:0]    d_conf_q;
  logic [1:0]          d_vld_q;
  entry_t [1:0]        head, cand, push_data;
  logic [CNT_W-1:0]    count, free, count_nxt;
  logic [1:0]          push_n, pop_n, nreq, nacc, ndrop;
  logic                hit0, hit1, miss0, miss1, miss, clr, have0, have1;
  entry_t              h1;
  logic [P_DROP_W-1:0] drop_q, drop_d;
  logic                full_q;

  vp_validator_fifo #(
    .T       (entry_t),
    .P_DEPTH (P_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr),
    .push_n_i    (push_n),
    .push_data_i (push_data),
    .pop_n_i     (pop_n),
    .head_o      (head),
    .count_o     (count)
  );

  // Lane1 compares against the entry behind lane0's pop, if any.
  assign have0 = count != '0;
  assign hit0  = ex_valid_i[0] && have0 && head[0].pc == ex_pc_i[0];
  assign miss0 = ex_valid_i[0] && have0 && head[0].pc != ex_pc_i[0];
  assign h1    = hit0 ? head[1] : head[0];
  assign have1 = hit0 ? (count > CNT_W'(1)) : have0;
  assign hit1  = ex_valid_i[1] && !miss0 && have1 && h1.pc == ex_pc_i[1];
  assign miss1 = ex_valid_i[1] && !miss0 && have1 && h1.pc != ex_pc_i[1];
  assign miss  = miss0 | miss1;
  assign clr   = flush_i | miss;
  assign pop_n = {1'b0, hit0} + {1'b0, hit1};

  always_comb begin
    cand[0] = '{pc: d_pc_q[0], pred: pred_result_e1_i[0], conf: d_conf_q[0]};
    cand[1] = '{pc: d_pc_q[1], pred: pred_result_e1_i[1], conf: d_conf_q[1]};
    push_data = cand;
    if (!d_vld_q[0]) push_data[0] = cand[1];
    nreq = {1'b0, d_vld_q[0]} + {1'b0, d_vld_q[1]};
    free = CNT_W'(P_DEPTH) - count;
    nacc = (free < CNT_W'(nreq)) ? free[1:0] : nreq;
    ndrop = nreq - nacc;
    push_n = nacc;
    if (clr) begin
      push_n = 2'd0;
      ndrop  = 2'd0;
    end
    count_nxt = clr ? '0 : count - CNT_W'(pop_n) + CNT_W'(push_n);
    drop_d = (drop_q > DROP_MAX - P_DROP_W'(ndrop)) ? DROP_MAX
           : drop_q + P_DROP_W'(ndrop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_pc_q          <= '0;
      d_conf_q        <= '0;
      d_vld_q         <= '0;
      fb_pc_o         <= '0;
      fb_actual_o     <= '0;
      fb_mispredict_o <= '0;
      fb_conf_o       <= '0;
      fb_valid_o      <= '0;
      resync_o        <= 1'b0;
      drop_q          <= '0;
      full_q          <= 1'b0;
    end else begin
      d_pc_q          <= pred_pc_d_i;
      d_conf_q        <= pred_conf_d_i;
      d_vld_q         <= flush_i ? 2'b00 : pred_valid_d_i;
      fb_valid_o      <= {hit1, hit0};
      fb_pc_o[0]      <= hit0 ? ex_pc_i[0] : '0;
      fb_pc_o[1]      <= hit1 ? ex_pc_i[1] : '0;
      fb_actual_o[0]  <= hit0 ? ex_result_i[0] : '0;
      fb_actual_o[1]  <= hit1 ? ex_result_i[1] : '0;
      fb_conf_o[0]    <= hit0 ? head[0].conf : '0;
      fb_conf_o[1]    <= hit1 ? h1.conf : '0;
      fb_mispredict_o <= {hit1 && (h1.pred != ex_result_i[1]),
                          hit0 && (head[0].pred != ex_result_i[0])};
      resync_o        <= miss;
      drop_q          <= drop_d;
      full_q          <= count_nxt >= CNT_W'(P_DEPTH - 1);
    end
  end

  assign count_o    = count;
  assign full_o     = full_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_vp_validator.sv
// Randomized bench for vp_validator against an in-order queue model.
// Directed sequences first, then random traffic phases.
module tb_vp_validator;
  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int CW1   = CW + 1;
  localparam int DW    = 16;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [1:0][31:1]    pred_pc_d_i;
  logic [1:0][CW:0]    pred_conf_d_i;
  logic [1:0]          pred_valid_d_i;
  logic [1:0][31:0]    pred_result_e1_i;
  logic [1:0][31:1]    ex_pc_i;
  logic [1:0][31:0]    ex_result_i;
  logic [1:0]          ex_valid_i;
  logic                flush_i;
  logic [1:0][31:1]    fb_pc_o;
  logic [1:0][31:0]    fb_actual_o;
  logic [1:0]          fb_mispredict_o;
  logic [1:0][CW:0]    fb_conf_o;
  logic [1:0]          fb_valid_o;
  logic                full_o;
  logic [CNTW-1:0]     count_o;
  logic [DW-1:0]       drop_cnt_o;
  logic                resync_o;

  vp_validator #(
    .P_CONF_WIDTH (CW),
    .P_DEPTH      (DEPTH),
    .P_DROP_W     (DW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pred_pc_d_i      (pred_pc_d_i),
    .pred_conf_d_i    (pred_conf_d_i),
    .pred_valid_d_i   (pred_valid_d_i),
    .pred_result_e1_i (pred_result_e1_i),
    .ex_pc_i          (ex_pc_i),
    .ex_result_i      (ex_result_i),
    .ex_valid_i       (ex_valid_i),
    .flush_i          (flush_i),
    .fb_pc_o          (fb_pc_o),
    .fb_actual_o      (fb_actual_o),
    .fb_mispredict_o  (fb_mispredict_o),
    .fb_conf_o        (fb_conf_o),
    .fb_valid_o       (fb_valid_o),
    .full_o           (full_o),
    .count_o          (count_o),
    .drop_cnt_o       (drop_cnt_o),
    .resync_o         (resync_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:1] pc;
    logic [31:0] pred;
    logic [CW:0] conf;
  } ent_t;

  ent_t             mq[$];
  logic [1:0]       m_dv;
  logic [1:0][31:1] m_dpc;
  logic [1:0][CW:0] m_dconf;
  int unsigned      m_drop;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dv    = '0;
    m_dpc   = '0;
    m_dconf = '0;
    m_drop  = 0;
  endtask

  task automatic idle();
    pred_pc_d_i      = '0;
    pred_conf_d_i    = '0;
    pred_valid_d_i   = '0;
    pred_result_e1_i = '0;
    ex_pc_i          = '0;
    ex_result_i      = '0;
    ex_valid_i       = '0;
    flush_i          = 1'b0;
  endtask

  // Advance one clock: predict from the current inputs, then compare.
  task automatic tick();
    logic [1:0]       e_v, e_mis;
    logic [1:0][CW:0] e_conf;
    logic [1:0][31:1] e_pc;
    logic [1:0][31:0] e_act;
    logic             e_rs;
    bit               stop;
    int               pre, free;
    e_v = '0; e_mis = '0; e_conf = '0; e_rs = 1'b0; stop = 0;
    e_pc = ex_pc_i; e_act = ex_result_i;
    pre = mq.size();
    for (int l = 0; l < 2; l++) begin
      if (ex_valid_i[l] && !stop && mq.size() > 0) begin
        if (mq[0].pc == ex_pc_i[l]) begin
          e_v[l]    = 1'b1;
          e_mis[l]  = mq[0].pred != ex_result_i[l];
          e_conf[l] = mq[0].conf;
          void'(mq.pop_front());
        end else begin
          e_rs = 1'b1;
          stop = 1;
        end
      end
    end
    if (flush_i || e_rs) mq.delete();
    else begin
      free = DEPTH - pre;
      for (int l = 0; l < 2; l++) begin
        if (m_dv[l]) begin
          if (free > 0) begin
            mq.push_back('{m_dpc[l], pred_result_e1_i[l], m_dconf[l]});
            free--;
          end else if (m_drop < (2 ** DW) - 1) m_drop++;
        end
      end
    end
    m_dv    = flush_i ? 2'b00 : pred_valid_d_i;
    m_dpc   = pred_pc_d_i;
    m_dconf = pred_conf_d_i;
    @(posedge clk_i);
    #1;
    check("fb_valid", 64'(fb_valid_o), 64'(e_v));
    for (int l = 0; l < 2; l++) begin
      if (e_v[l]) begin
        check($sformatf("fb_pc[%0d]", l), 64'(fb_pc_o[l]), 64'(e_pc[l]));
        check($sformatf("fb_actual[%0d]", l), 64'(fb_actual_o[l]),
              64'(e_act[l]));
        check($sformatf("fb_mispredict[%0d]", l),
              64'(fb_mispredict_o[l]), 64'(e_mis[l]));
        check($sformatf("fb_conf[%0d]", l), 64'(fb_conf_o[l]),
              64'(e_conf[l]));
      end
    end
    check("resync", 64'(resync_o), 64'(e_rs));
    check("count", 64'(count_o), 64'(mq.size()));
    check("full", 64'(full_o), 64'((DEPTH - mq.size()) < 2));
    check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
  endtask

  // Random inputs; ex lanes mostly target the model's head entries.
  task automatic rand_in(input int p_push, input int p_ex, input int p_fl);
    int idx;
    idx = 0;
    for (int l = 0; l < 2; l++) begin
      pred_valid_d_i[l]   = $urandom_range(99) < p_push;
      pred_pc_d_i[l]      = 31'($urandom);
      pred_conf_d_i[l]    = CW1'($urandom);
      pred_result_e1_i[l] = $urandom;
      ex_valid_i[l]       = $urandom_range(99) < p_ex;
      if (ex_valid_i[l] && idx < mq.size() && $urandom_range(99) < 93) begin
        ex_pc_i[l]     = mq[idx].pc;
        ex_result_i[l] = $urandom_range(1) ? mq[idx].pred : $urandom;
        idx++;
      end else begin
        ex_pc_i[l]     = 31'($urandom);
        ex_result_i[l] = $urandom;
      end
    end
    flush_i = $urandom_range(999) < p_fl;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fb_valid"}, 64'(fb_valid_o), 64'd0);
    check({tag, "_count"}, 64'(count_o), 64'd0);
    check({tag, "_full"}, 64'(full_o), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
    check({tag, "_resync"}, 64'(resync_o), 64'd0);
    check({tag, "_fb_pc"}, 64'(fb_pc_o), 64'd0);
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_i = 1'b0;

    // Match: push one prediction, then execute it with the same value.
    pred_valid_d_i = 2'b01; pred_pc_d_i[0] = 31'h80; pred_conf_d_i[0] = 9'h1FF;
    tick();
    idle(); pred_result_e1_i[0] = 32'h5;
    tick();
    check("t1_count1", 64'(count_o), 64'd1);
    idle(); ex_valid_i = 2'b01; ex_pc_i[0] = 31'h80; ex_result_i[0] = 32'h5;
    tick();
    check("t1_fb_valid", 64'(fb_valid_o), 64'h1);
    check("t1_conf", 64'(fb_conf_o[0]), 64'h1FF);
    check("t1_mis", 64'(fb_mispredict_o), 64'h0);

    // Mispredict: same flow with a different actual value.
    idle(); pred_valid_d_i = 2'b01; pred_pc_d_i[0] = 31'h80;
    pred_conf_d_i[0] = 9'h1FF;
    tick();
    idle(); pred_result_e1_i[0] = 32'h5;
    tick();
    idle(); ex_valid_i = 2'b01; ex_pc_i[0] = 31'h80; ex_result_i[0] = 32'h6;
    tick();
    check("t2_mis", 64'(fb_mispredict_o[0]), 64'h1);
    check("t2_actual", 64'(fb_actual_o[0]), 64'h6);

    // Fill past capacity with two pushes per cycle.
    for (int i = 0; i < 12; i++) begin
      rand_in(100, 0, 0);
      tick();
    end
    check("t3_count", 64'(count_o), 64'd16);
    check("t3_full", 64'(full_o), 64'd1);
    idle(); flush_i = 1'b1;
    tick();
    idle();
    tick();

    // Steady state: two in, two out, across several pointer wraps.
    idle(); pred_valid_d_i = 2'b11; pred_pc_d_i[0] = 31'h1000;
    pred_pc_d_i[1] = 31'h1002;
    tick();
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      rand_in(100, 0, 0);
      pred_valid_d_i = 2'b11;
      if (mq.size() >= 2) begin
        ex_valid_i = 2'b11;
        ex_pc_i[0] = mq[0].pc; ex_pc_i[1] = mq[1].pc;
      end
      tick();
    end
    check("t4_count", 64'(count_o), 64'd2);
    idle(); flush_i = 1'b1;
    tick();
    idle();
    tick();

    // PC mismatch on lane1 after a lane0 match.
    pred_valid_d_i = 2'b11; pred_pc_d_i[0] = 31'h100; pred_pc_d_i[1] = 31'h102;
    tick();
    idle(); pred_valid_d_i = 2'b01; pred_pc_d_i[0] = 31'h104;
    pred_result_e1_i = {32'h22, 32'h11};
    tick();
    idle(); pred_result_e1_i[0] = 32'h33;
    tick();
    idle(); ex_valid_i = 2'b11; ex_pc_i[0] = 31'h100; ex_pc_i[1] = 31'h180;
    ex_result_i[0] = 32'h11;
    tick();
    check("t5_fb_valid", 64'(fb_valid_o), 64'h1);
    check("t5_resync", 64'(resync_o), 64'h1);
    check("t5_count", 64'(count_o), 64'h0);

    // Flush with a pending push pair and a lane0 pop.
    idle(); pred_valid_d_i = 2'b11; pred_pc_d_i[0] = 31'h300;
    pred_pc_d_i[1] = 31'h302;
    tick();
    idle(); pred_valid_d_i = 2'b11; pred_pc_d_i[0] = 31'h304;
    pred_pc_d_i[1] = 31'h306;
    tick();
    idle(); flush_i = 1'b1; ex_valid_i = 2'b01; ex_pc_i[0] = 31'h300;
    tick();
    check("t6_fb_valid", 64'(fb_valid_o), 64'h1);
    check("t6_count", 64'(count_o), 64'h0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 20; i++) begin
      rand_in(90, 20, 0);
      tick();
    end
    #2;
    rst_i = 1'b1;
    #1;
    check_zero("midrst");
    idle();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();

    // Random phases: fill-heavy, balanced, drain-heavy.
    for (int i = 0; i < 1500; i++) begin
      case ((i / 100) % 3)
        0:       rand_in(85, 25, 4);
        1:       rand_in(60, 60, 4);
        default: rand_in(20, 90, 4);
      endcase
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
